// File: rtl/cpu_subsys_bus_bridge.sv
// Data-side host bridge: Ibex req/gnt/rvalid port to NUM_TGT valid/ready target ports.
// Base/mask window decode, per-target read-only protection, and a bounded access timeout.
module cpu_subsys_bus_bridge #(
    parameter int unsigned               NUM_TGT  = 3,
    parameter int unsigned               TGT_AW   = 30,
    parameter logic [NUM_TGT*32-1:0]     TGT_BASE = {32'h8000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_TGT*32-1:0]     TGT_MASK = {32'h7FFF_FFFF, 32'h0000_FFFF, 32'h0000_FFFF},
    parameter logic [NUM_TGT-1:0]        TGT_RO   = 3'b001,
    parameter int unsigned               TIMEOUT  = 255
) (
    input  logic                    sys_clk,
    input  logic                    rst,
    input  logic                    cpu_data_req_i,
    output logic                    cpu_data_gnt_o,
    output logic                    cpu_data_rvalid_o,
    input  logic                    cpu_data_we_i,
    input  logic [3:0]              cpu_data_be_i,
    input  logic [31:0]             cpu_data_addr_i,
    input  logic [31:0]             cpu_data_wdata_i,
    output logic [31:0]             cpu_data_rdata_o,
    output logic                    cpu_data_err_o,
    output logic [NUM_TGT-1:0]      tgt_valid_o,
    output logic [TGT_AW-1:0]       tgt_addr_o,
    output logic                    tgt_write_o,
    output logic [31:0]             tgt_wdata_o,
    output logic [3:0]              tgt_wstrb_o,
    input  logic [NUM_TGT*32-1:0]   tgt_rdata_i,
    input  logic [NUM_TGT-1:0]      tgt_ready_i,
    output logic                    err_pulse_o,
    output logic [31:0]             err_addr_o
);

    localparam int unsigned IW = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e              state_q;
    logic [31:0]         addr_q;
    logic [IW-1:0]       sel_q;
    logic [CW-1:0]       cnt_q;

    logic                dec_hit;
    logic [IW-1:0]       dec_idx;
    logic [TGT_AW-1:0]   dec_addr;
    logic [NUM_TGT-1:0]  dec_onehot;

    assign cpu_data_gnt_o = (state_q == StIdle) & cpu_data_req_i;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        dec_hit    = 1'b0;
        dec_idx    = '0;
        dec_addr   = '0;
        dec_onehot = '0;
        for (int i = NUM_TGT - 1; i >= 0; i--) begin
            if ((cpu_data_addr_i & ~TGT_MASK[i*32 +: 32]) ==
                (TGT_BASE[i*32 +: 32] & ~TGT_MASK[i*32 +: 32])) begin
                dec_hit  = 1'b1;
                dec_idx  = IW'(i);
                dec_addr = TGT_AW'((cpu_data_addr_i & TGT_MASK[i*32 +: 32]) >> 2);
            end
        end
        if (dec_hit) begin
            dec_onehot = NUM_TGT'(1) << dec_idx;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q           <= StIdle;
            addr_q            <= '0;
            sel_q             <= '0;
            cnt_q             <= '0;
            cpu_data_rvalid_o <= 1'b0;
            cpu_data_rdata_o  <= '0;
            cpu_data_err_o    <= 1'b0;
            tgt_valid_o       <= '0;
            tgt_addr_o        <= '0;
            tgt_write_o       <= 1'b0;
            tgt_wdata_o       <= '0;
            tgt_wstrb_o       <= '0;
            err_pulse_o       <= 1'b0;
            err_addr_o        <= '0;
        end else begin
            err_pulse_o <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cpu_data_req_i) begin
                        addr_q      <= cpu_data_addr_i;
                        sel_q       <= dec_idx;
                        cnt_q       <= '0;
                        tgt_addr_o  <= dec_addr;
                        tgt_write_o <= cpu_data_we_i;
                        tgt_wdata_o <= cpu_data_wdata_i;
                        tgt_wstrb_o <= cpu_data_we_i ? cpu_data_be_i : 4'b0000;
                        if (dec_hit && !(cpu_data_we_i && TGT_RO[dec_idx])) begin
                            tgt_valid_o <= dec_onehot;
                            state_q     <= StAccess;
                        end else begin
                            cpu_data_rvalid_o <= 1'b1;
                            cpu_data_err_o    <= 1'b1;
                            cpu_data_rdata_o  <= '0;
                            err_pulse_o       <= 1'b1;
                            err_addr_o        <= cpu_data_addr_i;
                            state_q           <= StResp;
                        end
                    end
                end
                StAccess: begin
                    if (tgt_ready_i[sel_q]) begin
                        tgt_valid_o       <= '0;
                        cpu_data_rvalid_o <= 1'b1;
                        cpu_data_err_o    <= 1'b0;
                        cpu_data_rdata_o  <= tgt_write_o ? 32'h0 : tgt_rdata_i[32*sel_q +: 32];
                        state_q           <= StResp;
                    end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                        tgt_valid_o       <= '0;
                        cpu_data_rvalid_o <= 1'b1;
                        cpu_data_err_o    <= 1'b1;
                        cpu_data_rdata_o  <= '0;
                        err_pulse_o       <= 1'b1;
                        err_addr_o        <= addr_q;
                        state_q           <= StResp;
                    end else if (cnt_q != {CW{1'b1}}) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StResp: begin
                    cpu_data_rvalid_o <= 1'b0;
                    cpu_data_err_o    <= 1'b0;
                    cpu_data_rdata_o  <= '0;
                    state_q           <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_subsys_bus_bridge.sv
// Directed table-driven bench for cpu_subsys_bus_bridge with default parameters,
// plus hand-written reset sequences.
module tb_cpu_subsys_bus_bridge;

    logic         sys_clk = 1'b0;
    logic         rst;
    logic         cpu_data_req_i;
    logic         cpu_data_gnt_o;
    logic         cpu_data_rvalid_o;
    logic         cpu_data_we_i;
    logic [3:0]   cpu_data_be_i;
    logic [31:0]  cpu_data_addr_i;
    logic [31:0]  cpu_data_wdata_i;
    logic [31:0]  cpu_data_rdata_o;
    logic         cpu_data_err_o;
    logic [2:0]   tgt_valid_o;
    logic [29:0]  tgt_addr_o;
    logic         tgt_write_o;
    logic [31:0]  tgt_wdata_o;
    logic [3:0]   tgt_wstrb_o;
    logic [95:0]  tgt_rdata_i;
    logic [2:0]   tgt_ready_i;
    logic         err_pulse_o;
    logic [31:0]  err_addr_o;

    cpu_subsys_bus_bridge dut (
        .sys_clk           (sys_clk),
        .rst               (rst),
        .cpu_data_req_i    (cpu_data_req_i),
        .cpu_data_gnt_o    (cpu_data_gnt_o),
        .cpu_data_rvalid_o (cpu_data_rvalid_o),
        .cpu_data_we_i     (cpu_data_we_i),
        .cpu_data_be_i     (cpu_data_be_i),
        .cpu_data_addr_i   (cpu_data_addr_i),
        .cpu_data_wdata_i  (cpu_data_wdata_i),
        .cpu_data_rdata_o  (cpu_data_rdata_o),
        .cpu_data_err_o    (cpu_data_err_o),
        .tgt_valid_o       (tgt_valid_o),
        .tgt_addr_o        (tgt_addr_o),
        .tgt_write_o       (tgt_write_o),
        .tgt_wdata_o       (tgt_wdata_o),
        .tgt_wstrb_o       (tgt_wstrb_o),
        .tgt_rdata_i       (tgt_rdata_i),
        .tgt_ready_i       (tgt_ready_i),
        .err_pulse_o       (err_pulse_o),
        .err_addr_o        (err_addr_o)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;      // ready on valid cycle delay+1
        logic [31:0] rdata;
        logic [2:0]  exp_valid;
        logic [29:0] exp_taddr;
        logic [3:0]  exp_wstrb;
        int          exp_vcnt;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        vecs[9];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_err_addr = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int  vcnt;
        bit  seen;
        vcnt = 0;
        seen = 0;
        @(negedge sys_clk);
        chk($sformatf("v%0d idle_rvalid", id), {31'b0, cpu_data_rvalid_o}, 32'h0);
        cpu_data_req_i   = 1'b1;
        cpu_data_we_i    = v.we;
        cpu_data_be_i    = v.be;
        cpu_data_addr_i  = v.addr;
        cpu_data_wdata_i = v.wdata;
        for (int t = 0; t < 3; t++) begin
            tgt_rdata_i[t*32 +: 32] = v.exp_valid[t] ? v.rdata : (32'hBAD0_0000 | t);
        end
        #1;
        chk($sformatf("v%0d gnt", id), {31'b0, cpu_data_gnt_o}, 32'h1);
        for (int cyc = 1; cyc <= 400 && !seen; cyc++) begin
            @(negedge sys_clk);
            cpu_data_req_i = 1'b0;
            if (tgt_valid_o != 3'b000) begin
                vcnt++;
                chk($sformatf("v%0d valid", id), {29'b0, tgt_valid_o}, {29'b0, v.exp_valid});
                chk($sformatf("v%0d taddr", id), {2'b0, tgt_addr_o}, {2'b0, v.exp_taddr});
                chk($sformatf("v%0d wstrb", id), {28'b0, tgt_wstrb_o}, {28'b0, v.exp_wstrb});
                chk($sformatf("v%0d write", id), {31'b0, tgt_write_o}, {31'b0, v.we});
                chk($sformatf("v%0d wdata", id), tgt_wdata_o, v.wdata);
                tgt_ready_i = (vcnt == v.delay + 1) ? v.exp_valid : 3'b000;
            end else begin
                tgt_ready_i = 3'b000;
            end
            if (cpu_data_rvalid_o) begin
                seen = 1;
                if (v.exp_err) exp_err_addr = v.addr;
                chk($sformatf("v%0d latency", id), cyc, v.exp_lat);
                chk($sformatf("v%0d valid_cycles", id), vcnt, v.exp_vcnt);
                chk($sformatf("v%0d err", id), {31'b0, cpu_data_err_o}, {31'b0, v.exp_err});
                chk($sformatf("v%0d rdata", id), cpu_data_rdata_o, v.exp_rdata);
                chk($sformatf("v%0d err_pulse", id), {31'b0, err_pulse_o}, {31'b0, v.exp_err});
                chk($sformatf("v%0d err_addr", id), err_addr_o, exp_err_addr);
            end
        end
        if (!seen) chk($sformatf("v%0d rvalid_never", id), 32'h0, 32'h1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " gnt"},      {31'b0, cpu_data_gnt_o},    32'h0);
        chk({tag, " rvalid"},   {31'b0, cpu_data_rvalid_o}, 32'h0);
        chk({tag, " rdata"},    cpu_data_rdata_o,           32'h0);
        chk({tag, " err"},      {31'b0, cpu_data_err_o},    32'h0);
        chk({tag, " valid"},    {29'b0, tgt_valid_o},       32'h0);
        chk({tag, " taddr"},    {2'b0, tgt_addr_o},         32'h0);
        chk({tag, " write"},    {31'b0, tgt_write_o},       32'h0);
        chk({tag, " wdata"},    tgt_wdata_o,                32'h0);
        chk({tag, " wstrb"},    {28'b0, tgt_wstrb_o},       32'h0);
        chk({tag, " pulse"},    {31'b0, err_pulse_o},       32'h0);
        chk({tag, " err_addr"}, err_addr_o,                 32'h0);
    endtask

    initial begin
        int rv_seen;
        int vc;
        //                we    be       addr           wdata          dly  rdata          valid   taddr     wstrb  vcnt lat  err   rdata
        vecs[0] = '{1'b0, 4'hF, 32'h1000_0010, 32'h0,         0,   32'hDEAD_BEEF, 3'b010, 30'd4,    4'h0,  1,   2,   1'b0, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 4'h3, 32'h8000_0104, 32'h1234_5678, 3,   32'h5555_AAAA, 3'b100, 30'd65,   4'h3,  4,   5,   1'b0, 32'h0};
        vecs[2] = '{1'b1, 4'hF, 32'h0000_0020, 32'hFFFF_0000, 0,   32'h0,         3'b000, 30'd0,    4'h0,  0,   1,   1'b1, 32'h0};
        vecs[3] = '{1'b0, 4'hF, 32'h0000_0020, 32'h0,         0,   32'h0BAD_F00D, 3'b001, 30'd8,    4'h0,  1,   2,   1'b0, 32'h0BAD_F00D};
        vecs[4] = '{1'b0, 4'hF, 32'h2000_0000, 32'h0,         0,   32'h0,         3'b000, 30'd0,    4'h0,  0,   1,   1'b1, 32'h0};
        vecs[5] = '{1'b1, 4'hF, 32'h1000_0008, 32'hCAFE_F00D, 1,   32'h9999_9999, 3'b010, 30'd2,    4'hF,  2,   3,   1'b0, 32'h0};
        vecs[6] = '{1'b0, 4'hF, 32'h1000_0100, 32'h0,         255, 32'h4444_4444, 3'b010, 30'h40,   4'h0,  255, 256, 1'b1, 32'h0};
        vecs[7] = '{1'b0, 4'hF, 32'h1000_0104, 32'h0,         254, 32'h7777_1111, 3'b010, 30'h41,   4'h0,  255, 256, 1'b0, 32'h7777_1111};
        vecs[8] = '{1'b0, 4'h1, 32'h8000_0003, 32'h0,         0,   32'h0102_0304, 3'b100, 30'd0,    4'h0,  1,   2,   1'b0, 32'h0102_0304};

        rst              = 1'b1;
        cpu_data_req_i   = 1'b0;
        cpu_data_we_i    = 1'b0;
        cpu_data_be_i    = 4'h0;
        cpu_data_addr_i  = 32'h0;
        cpu_data_wdata_i = 32'h0;
        tgt_rdata_i      = '0;
        tgt_ready_i      = 3'b000;
        repeat (3) @(negedge sys_clk);
        chk_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Reset in the middle of an SRAM access that never gets ready.
        @(negedge sys_clk);
        cpu_data_req_i  = 1'b1;
        cpu_data_we_i   = 1'b0;
        cpu_data_addr_i = 32'h1000_0020;
        tgt_ready_i     = 3'b000;
        @(negedge sys_clk);
        cpu_data_req_i = 1'b0;
        vc = 0;
        repeat (3) begin
            if (tgt_valid_o == 3'b010) vc++;
            @(negedge sys_clk);
        end
        chk("mid valid_before_rst", vc, 3);
        rst = 1'b1;
        #1;
        chk("mid valid_dropped", {29'b0, tgt_valid_o}, 32'h0);
        chk("mid rvalid", {31'b0, cpu_data_rvalid_o}, 32'h0);
        @(negedge sys_clk);
        chk_all_zero("in_rst");
        rst          = 1'b0;
        exp_err_addr = 32'h0;
        rv_seen = 0;
        repeat (5) begin
            @(posedge sys_clk);
            #1;
            if (cpu_data_rvalid_o || tgt_valid_o != 3'b000) rv_seen++;
        end
        chk("post_rst quiet", rv_seen, 0);
        run_vec(vecs[0], 10);
        run_vec(vecs[4], 11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_subsys_bus_bridge.md
# cpu_subsys_bus_bridge

Parametrised data-side host bridge between the Ibex data port (req/gnt/rvalid protocol) and `NUM_TGT` target memory ports (valid/ready protocol).
- Decodes each CPU access against per-target base/mask windows and enforces per-target read-only protection.
- Bounds every access with a timeout and returns bus errors on `cpu_data_err_o`.
- Sits in `cpu_subsys_top` and replaces the fixed three-way ROM/SRAM/peripheral bridge.

## Interface
Parameters:
- `NUM_TGT`, 3, number of target ports (1..8)
- `TGT_AW`, 30, target word-address width
- `TGT_BASE`, {32'h8000_0000, 32'h1000_0000, 32'h0000_0000}, packed `NUM_TGT*32` base addresses, target 0 in LSBs
- `TGT_MASK`, {32'h7FFF_FFFF, 32'h0000_FFFF, 32'h0000_FFFF}, packed offset masks; set bits are offset bits
- `TGT_RO`, 3'b001, per-target read-only bit
- `TIMEOUT`, 255, cycles to wait for `tgt_ready` before an error; 0 disables the timeout

Ports:
- `sys_clk` in 1: clock
- `rst` in 1: asynchronous, active-high reset
- `cpu_data_req_i` in 1: request
- `cpu_data_gnt_o` out 1: grant
- `cpu_data_rvalid_o` out 1: response valid
- `cpu_data_we_i` in 1: write enable
- `cpu_data_be_i` in 4: byte enables
- `cpu_data_addr_i` in 32: byte address
- `cpu_data_wdata_i` in 32: write data
- `cpu_data_rdata_o` out 32: read data
- `cpu_data_err_o` out 1: error, qualified by `cpu_data_rvalid_o`
- `tgt_valid_o` out NUM_TGT: one-hot target request
- `tgt_addr_o` out TGT_AW: word offset (shared by all targets)
- `tgt_write_o` out 1: write (shared)
- `tgt_wdata_o` out 32: write data (shared)
- `tgt_wstrb_o` out 4: byte strobes (shared)
- `tgt_rdata_i` in NUM_TGT*32: packed read data
- `tgt_ready_i` in NUM_TGT: per-target ready
- `err_pulse_o` out 1: one-cycle pulse for each error response
- `err_addr_o` out 32: byte address of the most recent errored access

## Operation
- Single outstanding transaction.
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - `cpu_data_gnt_o = cpu_data_req_i` (combinational); gnt is 0 in all other states.
  - On grant, capture addr/we/be/wdata.
  - Decode: target i hits when `(addr & ~MASK_i) == (BASE_i & ~MASK_i)`. Lowest index wins on overlap.
  - Hit, access allowed → ACCESS.
  - No hit → RESP with error.
  - Write to a `TGT_RO` target → RESP with error; no target access is issued.
- **ACCESS**
  - `tgt_valid_o[i]` is registered high.
  - `tgt_addr_o = (addr & MASK_i)[TGT_AW+1:2]`; `tgt_wstrb_o = be` for writes, 0 for reads.
  - `tgt_write_o`, `tgt_wdata_o`, `tgt_wstrb_o` and `tgt_addr_o` are held stable while valid is high.
  - When `tgt_ready_i[i]` is 1: capture `tgt_rdata_i[i]` (writes capture 0), drop valid in the next cycle, go to RESP with no error.
  - Timeout counter is cleared on entry and increments each ACCESS cycle. When it reaches `TIMEOUT` without ready: drop valid, go to RESP with error. A ready arriving in the same cycle as the limit wins (no error).
- **RESP**
  - `cpu_data_rvalid_o = 1` for exactly one cycle, then → IDLE.
  - `cpu_data_rdata_o` is valid only while rvalid is high, and reads 0 on error.
  - On error: `err_pulse_o = 1` in the RESP cycle, and `err_addr_o` updates to the captured address.
- **Reset**
  - Asserting `rst` mid-transaction returns the FSM to IDLE immediately, drops `tgt_valid_o`, and produces no rvalid.

## Timing
- **Reset values:** all outputs 0 (`cpu_data_gnt_o` follows `req` and is 0 unless req=1 in IDLE). The same applies while `rst` is high, including `err_addr_o` = 0.
- **Request to valid:** grant in cycle 0; `tgt_valid_o` high from cycle 1.
- **Ready to response:** ready seen in cycle k (k ≥ 1) gives rvalid in cycle k+1.
  - Minimum req→rvalid is 2 cycles.
  - Decode error or RO violation: rvalid in cycle 1.
- **Timeout:** with ready never asserted, valid is high for `TIMEOUT` cycles and rvalid+err arrive in cycle `TIMEOUT+1`.
- **Back-to-back:** the next grant is possible in the cycle after rvalid (IDLE).
- **Counter width:** `$clog2(TIMEOUT+1)`; it saturates and never wraps.

## Test plan
- Read SRAM: req addr 32'h1000_0010 with SRAM ready at once, `tgt_rdata_i[1]` = 32'hDEAD_BEEF → `tgt_valid_o` = 3'b010, `tgt_addr_o` = 4, rvalid 2 cycles after grant with rdata 32'hDEAD_BEEF, err 0.
- Peripheral write with a wait state: addr 32'h8000_0104, be 4'b0011, ready 3 cycles late → `tgt_valid_o` = 3'b100 held for 4 cycles, `tgt_addr_o` = 65, wstrb 4'b0011, rvalid err 0.
- RO violation: write to 32'h0000_0020 → no `tgt_valid_o`, rvalid in cycle 1 with err 1, `err_pulse_o` = 1, `err_addr_o` = 32'h0000_0020. A read of the same address succeeds.
- Decode miss: read 32'h2000_0000 → err 1, rdata 0 in cycle 1, no target access.
- Timeout: read SRAM with ready held 0 → valid for 255 cycles, rvalid+err in cycle 256. Ready arriving on cycle 255 → no error.
- Reset mid-ACCESS: assert `rst` while `tgt_valid_o[1]` = 1 → valid drops in the same cycle, no rvalid, and the next access after release completes normally.
